// File: rtl/window_gen_3x3.sv
// ---------------------------------------------------------------------------
// window_gen_3x3
//
// Streaming 3x3 window generator placed directly in front of the 9-cell
// processing element. It takes one pixel per accepted cycle in raster order.
// Two line buffers hold the previous two image rows. For every pixel that
// completes a full 3x3 neighbourhood, the block emits the nine pixels packed
// in PE cell order, together with a one-cycle enable.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-low reset
//   start      : one-cycle pulse; latches img_w / img_h and begins a frame
//   img_w      : image width in pixels  (legal 3..MAX_W)
//   img_h      : image height in rows   (legal 3..2^W_bits-1)
//   pix_in     : pixel data
//   pix_valid  : pix_in is valid this cycle (gaps allowed)
//   win        : window data, cell k at win[WIN_W-1-cell_bit*k -: cell_bit]
//                cell 0 = top-left, row-major, cell 8 = newest pixel
//   win_en     : win is valid this cycle (one pulse per window)
//   busy       : a frame is in progress
//   frame_done : one-cycle pulse when the frame completes
// ---------------------------------------------------------------------------
module window_gen_3x3 #(
  parameter int cell_bit = 8,
  parameter int N_cell   = 9,
  parameter int MAX_W    = 64,
  parameter int W_bits   = 7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [W_bits-1:0]            img_w,
  input  logic [W_bits-1:0]            img_h,
  input  logic [cell_bit-1:0]          pix_in,
  input  logic                         pix_valid,
  output logic [cell_bit*N_cell-1:0]   win,
  output logic                         win_en,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int WIN_W  = cell_bit * N_cell;
  localparam int A_bits = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int C      = cell_bit;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Control state
  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic [W_bits-1:0]   col_r;
  logic [W_bits-1:0]   row_r;
  logic [W_bits-1:0]   col_nxt_s;
  logic [W_bits-1:0]   row_nxt_s;
  logic [W_bits-1:0]   w_r;
  logic [W_bits-1:0]   h_r;
  logic [W_bits-1:0]   w_nxt_s;
  logic [W_bits-1:0]   h_nxt_s;

  // Per-cycle decode
  logic                dims_ok_s;
  logic                accept_s;
  logic                last_pix_s;
  logic                row_end_s;
  logic                win_hit_s;

  // Line buffers (no reset: contents are always rewritten before use)
  logic [C-1:0]        lb0_r [0:MAX_W-1];
  logic [C-1:0]        lb1_r [0:MAX_W-1];
  logic [A_bits-1:0]   lb_idx_s;
  logic [C-1:0]        lb0_rd_s;
  logic [C-1:0]        lb1_rd_s;

  // Window shift register and registered outputs
  logic [WIN_W-1:0]    win_reg_r;
  logic [WIN_W-1:0]    shift_s;
  logic [WIN_W-1:0]    win_r;
  logic                win_en_r;
  logic                busy_r;
  logic                frame_done_r;

  // Decode of dimensions, position and window completion
  always_comb begin
    dims_ok_s  = (img_w >= W_bits'(3)) && (img_w <= W_bits'(MAX_W)) &&
                 (img_h >= W_bits'(3));
    row_end_s  = (col_r == (w_r - W_bits'(1)));
    last_pix_s = row_end_s && (row_r == (h_r - W_bits'(1)));
    win_hit_s  = (row_r >= W_bits'(2)) && (col_r >= W_bits'(2));
  end

  // Line buffer read port; col_r never exceeds MAX_W-1 so the low bits index it
  always_comb begin
    lb_idx_s = col_r[A_bits-1:0];
    lb0_rd_s = lb0_r[lb_idx_s];
    lb1_rd_s = lb1_r[lb_idx_s];
  end

  // Window shifted left by one column, new right column = {row-2, row-1, pix}
  always_comb begin
    shift_s = {win_reg_r[8*C-1:6*C], lb0_rd_s,
               win_reg_r[5*C-1:3*C], lb1_rd_s,
               win_reg_r[2*C-1:0],   pix_in};
  end

  // Next-state logic for FSM, counters and latched dimensions
  always_comb begin
    state_nxt_s = state_r;
    col_nxt_s   = col_r;
    row_nxt_s   = row_r;
    w_nxt_s     = w_r;
    h_nxt_s     = h_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && dims_ok_s) begin
          state_nxt_s = RUN;
          w_nxt_s     = img_w;
          h_nxt_s     = img_h;
          col_nxt_s   = {W_bits{1'b0}};
          row_nxt_s   = {W_bits{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN, DONE: begin
        if (start) begin
          // Restart takes priority over any pixel offered in the same cycle
          col_nxt_s = {W_bits{1'b0}};
          row_nxt_s = {W_bits{1'b0}};
          if (dims_ok_s) begin
            state_nxt_s = RUN;
            w_nxt_s     = img_w;
            h_nxt_s     = img_h;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (state_r == DONE) begin
          state_nxt_s = IDLE;
        end else if (pix_valid) begin
          accept_s = 1'b1;
          if (last_pix_s) begin
            state_nxt_s = DONE;
            col_nxt_s   = {W_bits{1'b0}};
            row_nxt_s   = {W_bits{1'b0}};
          end else if (row_end_s) begin
            col_nxt_s = {W_bits{1'b0}};
            row_nxt_s = row_r + W_bits'(1);
          end else begin
            col_nxt_s = col_r + W_bits'(1);
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        col_nxt_s   = {W_bits{1'b0}};
        row_nxt_s   = {W_bits{1'b0}};
      end
    endcase
  end

  // Control registers, window register and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      col_r        <= {W_bits{1'b0}};
      row_r        <= {W_bits{1'b0}};
      w_r          <= {W_bits{1'b0}};
      h_r          <= {W_bits{1'b0}};
      win_reg_r    <= {WIN_W{1'b0}};
      win_r        <= {WIN_W{1'b0}};
      win_en_r     <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      col_r        <= col_nxt_s;
      row_r        <= row_nxt_s;
      w_r          <= w_nxt_s;
      h_r          <= h_nxt_s;
      // busy covers RUN and the single DONE cycle
      busy_r       <= (state_nxt_s != IDLE);
      // DONE is only entered on the final accepted pixel
      frame_done_r <= (state_nxt_s == DONE);
      win_en_r     <= accept_s && win_hit_s;
      if (accept_s) begin
        win_reg_r <= shift_s;
      end
      // Output only updates on a full window so it holds between pulses
      if (accept_s && win_hit_s) begin
        win_r <= shift_s;
      end
    end
  end

  // Line buffer update: row-1 data moves up to row-2, new pixel becomes row-1
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb0_r[lb_idx_s] <= lb1_rd_s;
      lb1_r[lb_idx_s] <= pix_in;
    end
  end

  assign win        = win_r;
  assign win_en     = win_en_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_window_gen_3x3.sv
// ---------------------------------------------------------------------------
// tb_window_gen_3x3
//
// Self-checking bench for window_gen_3x3. Reference windows are computed from
// a pixel-pattern function and pushed to a queue when the completing pixel is
// driven; they are popped when the DUT raises win_en.
// ---------------------------------------------------------------------------
module tb_window_gen_3x3;

  logic         clk;
  logic         reset;
  logic         start;
  logic [6:0]   img_w;
  logic [6:0]   img_h;
  logic [7:0]   pix_in;
  logic         pix_valid;
  logic [71:0]  win;
  logic         win_en;
  logic         busy;
  logic         frame_done;

  int           n_vec;
  int           n_bad;
  int           nwin;
  logic [71:0]  last_win;
  logic [71:0]  exp_q [$];

  window_gen_3x3 dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .img_w      (img_w),
    .img_h      (img_h),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .win        (win),
    .win_en     (win_en),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run can never hang
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Pixel patterns: 0 = 16r+c, 1 = 64r+c (wide image), 2 = distinct old-frame data
  function automatic logic [7:0] pat(input int sel, input int r, input int c);
    int v;
    case (sel)
      0:       v = 16 * r + c;
      1:       v = 64 * r + c;
      default: v = 8'hA5 ^ (16 * r + c);
    endcase
    return 8'(v & 255);
  endfunction

  function automatic logic [71:0] win_ref(input int sel, input int r, input int c);
    logic [71:0] w;
    w = 72'd0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        w = {w[63:0], pat(sel, r - 2 + dr, c - 2 + dc)};
      end
    end
    return w;
  endfunction

  // One clock; sample #1 after the edge and compare against expectations
  task automatic tick(input logic e_en, input logic e_done, input logic e_busy);
    logic [71:0] e;
    @(posedge clk);
    #1;
    check_val("win_en", 72'(win_en), 72'(e_en));
    check_val("frame_done", 72'(frame_done), 72'(e_done));
    check_val("busy", 72'(busy), 72'(e_busy));
    if (win_en === 1'b1) begin
      nwin = nwin + 1;
      if (exp_q.size() == 0) begin
        check_val("win_extra", 72'(1), 72'(0));
      end else begin
        e = exp_q.pop_front();
        check_val("win", win, e);
        last_win = e;
      end
    end else begin
      check_val("win_hold", win, last_win);
    end
  endtask

  task automatic start_frame(input int w, input int h, input logic e_busy);
    start = 1'b1;
    img_w = 7'(w);
    img_h = 7'(h);
    tick(1'b0, 1'b0, e_busy);
    start = 1'b0;
  endtask

  task automatic feed(input int r, input int c, input int w, input int h, input int sel);
    logic hit;
    hit       = (r >= 2) && (c >= 2);
    pix_valid = 1'b1;
    pix_in    = pat(sel, r, c);
    if (hit) exp_q.push_back(win_ref(sel, r, c));
    tick(hit, (r == h - 1) && (c == w - 1), 1'b1);
    pix_valid = 1'b0;
  endtask

  task automatic finish_frame(input int n_exp);
    tick(1'b0, 1'b0, 1'b0);
    check_val("nwin", 72'(nwin), 72'(n_exp));
    check_val("q_empty", 72'(exp_q.size()), 72'(0));
    exp_q.delete();
  endtask

  task automatic run_frame(input int w, input int h, input int sel, input logic gap);
    start_frame(w, h, 1'b1);
    nwin = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        feed(r, c, w, h, sel);
        if (gap && !((r == h - 1) && (c == w - 1))) begin
          pix_in = 8'($urandom_range(0, 255));
          tick(1'b0, 1'b0, 1'b1);
        end
      end
    end
    finish_frame((w - 2) * (h - 2));
  endtask

  task automatic illegal_start(input int w, input int h);
    start_frame(w, h, 1'b0);
    for (int i = 0; i < 16; i++) begin
      pix_valid = 1'b1;
      pix_in    = 8'(i);
      tick(1'b0, 1'b0, 1'b0);
    end
    pix_valid = 1'b0;
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    nwin      = 0;
    last_win  = 72'd0;
    reset     = 1'b0;
    start     = 1'b0;
    img_w     = 7'd0;
    img_h     = 7'd0;
    pix_in    = 8'd0;
    pix_valid = 1'b0;

    // Reset state
    #12;
    check_val("rst_win", win, 72'd0);
    check_val("rst_win_en", 72'(win_en), 72'd0);
    check_val("rst_busy", 72'(busy), 72'd0);
    check_val("rst_frame_done", 72'(frame_done), 72'd0);
    @(negedge clk);
    reset = 1'b1;

    // Basic 4x4 frame, continuous input
    run_frame(4, 4, 0, 1'b0);
    // Same image with pix_valid toggling
    run_frame(4, 4, 0, 1'b1);
    // Maximum width
    run_frame(64, 3, 1, 1'b0);

    // Restart at row 2, col 1 of a 5x5 frame, with a pixel offered alongside start
    start_frame(5, 5, 1'b1);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 5; c++) feed(r, c, 5, 5, 2);
    end
    feed(2, 0, 5, 5, 2);
    start     = 1'b1;
    img_w     = 7'd4;
    img_h     = 7'd4;
    pix_valid = 1'b1;
    pix_in    = pat(2, 2, 1);
    tick(1'b0, 1'b0, 1'b1);
    start     = 1'b0;
    pix_valid = 1'b0;
    nwin      = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) feed(r, c, 4, 4, 0);
    end
    finish_frame(4);

    // Illegal dimensions are ignored
    illegal_start(2, 4);
    illegal_start(65, 4);

    // Asynchronous reset in the middle of a frame, right after a window
    start_frame(4, 4, 1'b1);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) feed(r, c, 4, 4, 0);
    end
    for (int c = 0; c < 3; c++) feed(2, c, 4, 4, 0);
    #2;
    reset = 1'b0;
    #1;
    check_val("arst_win", win, 72'd0);
    check_val("arst_win_en", 72'(win_en), 72'd0);
    check_val("arst_busy", 72'(busy), 72'd0);
    check_val("arst_frame_done", 72'(frame_done), 72'd0);
    exp_q.delete();
    last_win = 72'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    // Stays idle without start
    for (int i = 0; i < 8; i++) begin
      pix_valid = 1'b1;
      pix_in    = 8'(i + 40);
      tick(1'b0, 1'b0, 1'b0);
    end
    pix_valid = 1'b0;
    // A fresh frame works after reset
    run_frame(4, 4, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Streaming 3x3 window generator that sits directly upstream of the 9-cell processing element. It accepts one 8-bit pixel per cycle in raster order and keeps the two previous image rows in internal line buffers. For every pixel position that completes a full 3x3 neighbourhood, it emits the 9 pixels packed in PE cell order, together with a one-cycle enable that drives the PE `en` input.

## Interface
- `cell_bit`, 8: bits per pixel/cell.
- `N_cell`, 9: cells per window (fixed 3x3; no other value is supported).
- `MAX_W`, 64: maximum image width, i.e. line-buffer depth in pixels.
- `W_bits`, 7: width of the column/row counters and of `img_w` / `img_h`. Must satisfy 2^`W_bits` > `MAX_W`.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse; latches `img_w` / `img_h` and begins a frame.
- `img_w` input `W_bits`: image width in pixels; legal range 3..`MAX_W`.
- `img_h` input `W_bits`: image height in rows; legal range 3..2^`W_bits`-1.
- `pix_in` input `cell_bit`: pixel data.
- `pix_valid` input 1: `pix_in` is valid this cycle. Gaps between valid pixels are allowed.
- `win` output `cell_bit*N_cell` (72): window data.
  - Cell k occupies `win[71-8k -: 8]`.
  - Cell 0 is top-left; order is row-major; cell 8 is bottom-right, i.e. the newest pixel.
- `win_en` output 1: `win` is valid this cycle.
- `busy` output 1: a frame is in progress.
- `frame_done` output 1: one-cycle pulse when the frame completes.

## Operation
- FSM states:
  - IDLE
    - `start` with legal `img_w` / `img_h`: latch both values, clear `col`/`row`, go to RUN.
    - `start` with illegal dimensions: ignored; remain in IDLE with no other effect.
    - `pix_valid` is ignored in IDLE.
  - RUN
    - Each cycle with `pix_valid`=1 accepts `pix_in` at position (`row`, `col`).
    - Accepting the pixel at (`img_h`-1, `img_w`-1) moves the FSM to DONE.
  - DONE: lasts one cycle, asserts `frame_done`, then returns to IDLE.
- `start` in RUN or DONE restarts the frame: counters clear, the new dimensions are latched (if legal), and no `win_en` is produced for pixels of the aborted frame after that edge. If the new dimensions are illegal, the FSM goes to IDLE.
- On each accepted pixel at column c:
  - Read `lb0[c]` (row-2) and `lb1[c]` (row-1).
  - Shift the 3-column window register left by one column; the new right column is {`lb0[c]`, `lb1[c]`, `pix_in`}, top to bottom.
  - Write `lb0[c]` <= `lb1[c]` and `lb1[c]` <= `pix_in`.
  - Advance `col`; it wraps to 0 after `img_w`-1, and `row` increments on each wrap.
- `win_en` is asserted for the accepted pixel iff `row` >= 2 and `col` >= 2. The window never mixes data from two different rows' ends.
- Windows per frame: (`img_w`-2)*(`img_h`-2).
- Line buffers are plain register arrays with no reset. The window register, counters, FSM and all outputs are reset.
- Pixel data is passed through unmodified; signedness is interpreted by the PE.

## Timing
- Reset values: `win`=0, `win_en`=0, `busy`=0, `frame_done`=0, FSM=IDLE, `col`=`row`=0.
- Latency is 1 cycle: `win` and `win_en` are registered and appear the cycle after the accepting edge. The bottom-right cell of `win` is that accepted pixel.
- `win_en` is high for exactly one cycle per window. `win` holds its value when `win_en`=0.
- `busy` is 1 from the cycle after `start` is accepted until the cycle `frame_done` is high, inclusive.
- `frame_done` rises in the same cycle as the final window's `win_en`.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronously), with no `frame_done`. The next frame requires a new `start`.
- Simultaneous `start` and `pix_valid` in RUN: `start` wins and the pixel is dropped.
- `pix_valid` gaps do not affect output contents; `win_en` simply follows the accepted pixels with 1-cycle latency.

## Test plan
- Basic 4x4 frame:
  - Stimulus: `img_w`=`img_h`=4, `pix_in`=16r+c, continuous `pix_valid`.
  - Required: exactly 4 `win_en` pulses.
  - First window: `win`=72'h00_01_02_10_11_12_20_21_22, one cycle after pixel 0x22 is accepted.
  - Last window: 72'h11_12_13_21_22_23_31_32_33, with `frame_done` in the same cycle.
- Gapped input: same image as the basic test with `pix_valid` toggling 1/0.
  - Required: identical `win` sequence.
  - Each `win_en` occurs exactly one cycle after its completing pixel is accepted.
- Maximum width:
  - Stimulus: `img_w`=64, `img_h`=3.
  - Required: 62 windows; the first is cols 0-2 and the last is cols 61-63.
  - No wrap corruption: the window at col 2 contains no col-63 data.
- Restart mid-frame:
  - Stimulus: `start` asserted at row 2, col 1 of a 5x5 frame, then a full 4x4 frame.
  - Required: no window from old data appears after the restart edge; the exactly 4 subsequent windows match the 4x4 reference.
- Illegal dimensions:
  - Stimulus: `start` with `img_w`=2, and separately with `img_w`=65.
  - Required: `busy` stays 0 and pixels produce no `win_en`.
- Asynchronous reset:
  - Stimulus: assert `reset`=0 between clock edges during RUN.
  - Required: `win_en`, `busy`, `frame_done` and `win` are 0 before the next edge.
  - Required: after release, the FSM stays in IDLE until `start`.
